// File: rtl/riscv_instr_encoder_if.sv
// Request/word-stream bundle between the program sequencer and the RV32I encoder.
interface riscv_instr_encoder_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_fmt;
   logic [6:0]  req_opcode;
   logic [2:0]  req_funct3;
   logic [6:0]  req_funct7;
   logic [4:0]  req_rd;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [31:0] req_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        err;

   modport master (
      output req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
             req_rd, req_rs1, req_rs2, req_imm, out_ready,
      input  req_ready, out_valid, out_instr, out_last, err
   );

   modport slave (
      input  req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
             req_rd, req_rs1, req_rs2, req_imm, out_ready,
      output req_ready, out_valid, out_instr, out_last, err
   );
endinterface

// File: rtl/riscv_instr_encoder.sv
// Packs op fields plus a 32-bit immediate into RV32I words; LI expands to LUI/ADDI.
//  state    | meaning
//  S_IDLE   | ready for a request
//  S_EMIT1  | first word valid on out_instr
//  S_EMIT2  | second LI word (ADDI) valid on out_instr
//  S_REJECT | err pulse cycle, no word emitted
module riscv_instr_encoder #(
   parameter bit CHECK_RANGE = 1'b1,
   parameter bit ALLOW_LI    = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   riscv_instr_encoder_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_EMIT1, S_EMIT2, S_REJECT} state_t;

   localparam logic [6:0] OP_ADDI = 7'h13;
   localparam logic [6:0] OP_LUI  = 7'h37;

   state_t      r_state;
   logic        r_out_valid;
   logic [31:0] r_out_instr;
   logic        r_out_last;
   logic        r_err;
   logic [31:0] r_word2;

   logic [31:0] w_imm;
   logic        w_fit12, w_fit13, w_fit21, w_lo_zero;
   logic [19:0] w_li_hi;
   logic [31:0] w_word1, w_word2;
   logic        w_last1, w_range_bad, w_reserved, w_err;

   assign w_imm     = bus.req_imm;
   assign w_fit12   = (&w_imm[31:11]) | ~(|w_imm[31:11]);
   assign w_fit13   = (&w_imm[31:12]) | ~(|w_imm[31:12]);
   assign w_fit21   = (&w_imm[31:20]) | ~(|w_imm[31:20]);
   assign w_lo_zero = ~(|w_imm[11:0]);
   // Upper part rounded so the sign-extended ADDI low half lands back on imm.
   assign w_li_hi   = w_imm[31:12] + {19'd0, w_imm[11]};

   always_comb begin
      w_word1     = '0;
      w_word2     = '0;
      w_last1     = 1'b1;
      w_range_bad = 1'b0;
      w_reserved  = 1'b0;
      case (bus.req_fmt)
         3'd0: w_word1 = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3,
                          bus.req_rd, bus.req_opcode};
         3'd1: begin
            w_word1     = {w_imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, bus.req_opcode};
            w_range_bad = ~w_fit12;
         end
         3'd2: begin
            w_word1     = {w_imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                           w_imm[4:0], bus.req_opcode};
            w_range_bad = ~w_fit12;
         end
         3'd3: begin
            w_word1     = {w_imm[12], w_imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                           w_imm[4:1], w_imm[11], bus.req_opcode};
            w_range_bad = ~w_fit13 | w_imm[0];
         end
         3'd4: begin
            w_word1     = {w_imm[31:12], bus.req_rd, bus.req_opcode};
            w_range_bad = ~w_lo_zero;
         end
         3'd5: begin
            w_word1     = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                           bus.req_rd, bus.req_opcode};
            w_range_bad = ~w_fit21 | w_imm[0];
         end
         3'd6: begin
            w_reserved = ~ALLOW_LI;
            if (w_fit12) begin
               w_word1 = {w_imm[11:0], 5'd0, 3'b000, bus.req_rd, OP_ADDI};
            end else if (w_lo_zero) begin
               w_word1 = {w_imm[31:12], bus.req_rd, OP_LUI};
            end else begin
               w_word1 = {w_li_hi, bus.req_rd, OP_LUI};
               w_word2 = {w_imm[11:0], bus.req_rd, 3'b000, bus.req_rd, OP_ADDI};
               w_last1 = 1'b0;
            end
         end
         default: w_reserved = 1'b1;
      endcase
   end

   assign w_err = w_reserved | (CHECK_RANGE & w_range_bad);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_last  <= 1'b0;
         r_err       <= 1'b0;
         r_word2     <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  if (w_err) begin
                     r_err   <= 1'b1;
                     r_state <= S_REJECT;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_out_instr <= w_word1;
                     r_out_last  <= w_last1;
                     r_word2     <= w_word2;
                     r_state     <= S_EMIT1;
                  end
               end
            end
            S_EMIT1: begin
               if (bus.out_ready) begin
                  if (r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_state     <= S_IDLE;
                  end else begin
                     r_out_instr <= r_word2;
                     r_out_last  <= 1'b1;
                     r_state     <= S_EMIT2;
                  end
               end
            end
            S_EMIT2: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.out_instr = r_out_instr;
   assign bus.out_last  = r_out_last;
   assign bus.err       = r_err;
endmodule
